// File: rtl/video_timing_gen_if.sv
// Raster timing bus from the timing generator to the output encoder and the framebuffer fetch unit.
// The generator drives it through the master modport; consumers read it through the slave modport.
interface video_timing_gen_if;
  logic [11:0] x;
  logic [10:0] y;
  logic        de;
  logic        hsync;
  logic        vsync;
  logic        line_start;
  logic        frame_start;

  modport master (output x, y, de, hsync, vsync, line_start, frame_start);
  modport slave  (input  x, y, de, hsync, vsync, line_start, frame_start);
endinterface

// File: rtl/video_timing_gen.sv
// Raster timing generator: walks an x/y raster (active, front porch, sync, back porch) once per pixel enable
// and drives registered coordinates, syncs, data-enable and line/frame strobes with zero latency to the counters.
module video_timing_gen #(
  parameter int unsigned H_ACTIVE = 1920,
  parameter int unsigned H_FP     = 88,
  parameter int unsigned H_SYNC   = 44,
  parameter int unsigned H_BP     = 148,
  parameter int unsigned V_ACTIVE = 1080,
  parameter int unsigned V_FP     = 4,
  parameter int unsigned V_SYNC   = 5,
  parameter int unsigned V_BP     = 36,
  parameter bit          HS_POL   = 1'b1,
  parameter bit          VS_POL   = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                pix_en,
  video_timing_gen_if.master  vid
);

  localparam int unsigned H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_START   = H_ACTIVE + H_FP;
  localparam int unsigned HS_END     = H_ACTIVE + H_FP + H_SYNC;
  localparam int unsigned VS_START   = V_ACTIVE + V_FP;
  localparam int unsigned VS_END     = V_ACTIVE + V_FP + V_SYNC;
  localparam logic [11:0] H_LAST     = 12'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);

  logic [11:0] h_cnt;
  logic [10:0] v_cnt;
  logic [11:0] h_next;
  logic [10:0] v_next;
  logic        de_next;
  logic        hsync_on;
  logic        vsync_on;

  // Next raster position, used both for the counter update and for decoding the outputs on the same edge.
  always_comb begin
    h_next = h_cnt + 12'd1;
    v_next = v_cnt;
    if (h_cnt == H_LAST) begin
      h_next = '0;
      v_next = (v_cnt == V_LAST) ? '0 : v_cnt + 11'd1;
    end
  end

  always_comb begin
    de_next  = (32'(h_next) < H_ACTIVE) && (32'(v_next) < V_ACTIVE);
    hsync_on = (32'(h_next) >= HS_START) && (32'(h_next) < HS_END);
    vsync_on = (32'(v_next) >= VS_START) && (32'(v_next) < VS_END);
  end

  // Reset parks the counters on the last pixel of the frame so the first enable lands on pixel (0,0).
  always_ff @(posedge clk) begin
    if (!reset) begin
      h_cnt <= H_LAST;
      v_cnt <= V_LAST;
    end else if (pix_en) begin
      h_cnt <= h_next;
      v_cnt <= v_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      vid.x           <= '0;
      vid.y           <= '0;
      vid.de          <= 1'b0;
      vid.hsync       <= !HS_POL;
      vid.vsync       <= !VS_POL;
      vid.line_start  <= 1'b0;
      vid.frame_start <= 1'b0;
    end else if (pix_en) begin
      vid.x           <= de_next ? h_next : '0;
      vid.y           <= de_next ? v_next : '0;
      vid.de          <= de_next;
      vid.hsync       <= hsync_on ? HS_POL : !HS_POL;
      vid.vsync       <= vsync_on ? VS_POL : !VS_POL;
      vid.line_start  <= (h_next == '0);
      vid.frame_start <= (h_next == '0) && (v_next == '0);
    end else begin
      vid.line_start  <= 1'b0;
      vid.frame_start <= 1'b0;
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// Self-checking bench: a default 1080p instance and a tiny-raster instance share random stimulus
// and are compared every clock against a frame-position reference model.
module tb_video_timing_gen;

  typedef struct packed {
    logic [11:0] x;
    logic [10:0] y;
    logic        de;
    logic        hsync;
    logic        vsync;
    logic        line_start;
    logic        frame_start;
  } vid_t;

  localparam int D_HA = 1920, D_HFP = 88, D_HS = 44, D_HBP = 148;
  localparam int D_VA = 1080, D_VFP = 4,  D_VS = 5,  D_VBP = 36;
  localparam int S_HA = 8,    S_HFP = 2,  S_HS = 2,  S_HBP = 2;
  localparam int S_VA = 4,    S_VFP = 1,  S_VS = 1,  S_VBP = 1;
  localparam int D_HT = D_HA + D_HFP + D_HS + D_HBP;
  localparam int D_VT = D_VA + D_VFP + D_VS + D_VBP;
  localparam int S_HT = S_HA + S_HFP + S_HS + S_HBP;
  localparam int S_VT = S_VA + S_VFP + S_VS + S_VBP;

  logic clk = 1'b0;
  logic reset;
  logic pix_en;

  video_timing_gen_if vid_d ();
  video_timing_gen_if vid_s ();

  video_timing_gen dut_d (
    .clk    (clk),
    .reset  (reset),
    .pix_en (pix_en),
    .vid    (vid_d)
  );

  video_timing_gen #(
    .H_ACTIVE (S_HA), .H_FP (S_HFP), .H_SYNC (S_HS), .H_BP (S_HBP),
    .V_ACTIVE (S_VA), .V_FP (S_VFP), .V_SYNC (S_VS), .V_BP (S_VBP),
    .HS_POL   (1'b0), .VS_POL (1'b1)
  ) dut_s (
    .clk    (clk),
    .reset  (reset),
    .pix_en (pix_en),
    .vid    (vid_s)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference state: linear pixel index within the frame, plus pending strobes.
  int p_d, p_s;
  bit in_reset;
  bit ls_d, fs_d, ls_s, fs_s;
  int cycle = 0;

  function automatic vid_t expect_vid(int p, bit held_reset, bit ls, bit fs,
                                      int ha, int hfp, int hsw, int hbp,
                                      int va, int vfp, int vsw, bit hpol, bit vpol);
    vid_t e;
    int ht = ha + hfp + hsw + hbp;
    int h  = p % ht;
    int v  = p / ht;
    e = '0;
    if (held_reset) begin
      e.hsync = !hpol;
      e.vsync = !vpol;
      return e;
    end
    e.de          = (h < ha) && (v < va);
    e.x           = e.de ? 12'(h) : 12'd0;
    e.y           = e.de ? 11'(v) : 11'd0;
    e.hsync       = (h >= ha + hfp && h < ha + hfp + hsw) ? hpol : !hpol;
    e.vsync       = (v >= va + vfp && v < va + vfp + vsw) ? vpol : !vpol;
    e.line_start  = ls;
    e.frame_start = fs;
    return e;
  endfunction

  task automatic check_output(input string tag, input vid_t obs, input vid_t exp);
    checks++;
    assert (obs.x === exp.x) else begin
      errors++; $error("[TB] FAIL %s.x cyc %0d observed %0d expected %0d", tag, cycle, obs.x, exp.x);
    end
    checks++;
    assert (obs.y === exp.y) else begin
      errors++; $error("[TB] FAIL %s.y cyc %0d observed %0d expected %0d", tag, cycle, obs.y, exp.y);
    end
    checks++;
    assert (obs.de === exp.de) else begin
      errors++; $error("[TB] FAIL %s.de cyc %0d observed %b expected %b", tag, cycle, obs.de, exp.de);
    end
    checks++;
    assert (obs.hsync === exp.hsync) else begin
      errors++; $error("[TB] FAIL %s.hsync cyc %0d observed %b expected %b", tag, cycle, obs.hsync, exp.hsync);
    end
    checks++;
    assert (obs.vsync === exp.vsync) else begin
      errors++; $error("[TB] FAIL %s.vsync cyc %0d observed %b expected %b", tag, cycle, obs.vsync, exp.vsync);
    end
    checks++;
    assert (obs.line_start === exp.line_start) else begin
      errors++; $error("[TB] FAIL %s.line_start cyc %0d observed %b expected %b", tag, cycle, obs.line_start, exp.line_start);
    end
    checks++;
    assert (obs.frame_start === exp.frame_start) else begin
      errors++; $error("[TB] FAIL %s.frame_start cyc %0d observed %b expected %b", tag, cycle, obs.frame_start, exp.frame_start);
    end
  endtask

  function automatic vid_t observe_d();
    return '{vid_d.x, vid_d.y, vid_d.de, vid_d.hsync, vid_d.vsync, vid_d.line_start, vid_d.frame_start};
  endfunction

  function automatic vid_t observe_s();
    return '{vid_s.x, vid_s.y, vid_s.de, vid_s.hsync, vid_s.vsync, vid_s.line_start, vid_s.frame_start};
  endfunction

  // Drive one clock of stimulus, advance the reference model and compare both instances.
  task automatic apply_stimulus(input bit r, input bit e);
    reset  = r;
    pix_en = e;
    @(posedge clk);
    #1;
    cycle++;
    if (!r) begin
      p_d = D_HT * D_VT - 1;
      p_s = S_HT * S_VT - 1;
      in_reset = 1'b1;
      {ls_d, fs_d, ls_s, fs_s} = '0;
    end else if (e) begin
      p_d = (p_d + 1) % (D_HT * D_VT);
      p_s = (p_s + 1) % (S_HT * S_VT);
      in_reset = 1'b0;
      ls_d = (p_d % D_HT) == 0;
      fs_d = (p_d == 0);
      ls_s = (p_s % S_HT) == 0;
      fs_s = (p_s == 0);
    end else begin
      {ls_d, fs_d, ls_s, fs_s} = '0;
    end
    check_output("dflt", observe_d(),
                 expect_vid(p_d, in_reset, ls_d, fs_d, D_HA, D_HFP, D_HS, D_HBP, D_VA, D_VFP, D_VS, 1'b1, 1'b1));
    check_output("small", observe_s(),
                 expect_vid(p_s, in_reset, ls_s, fs_s, S_HA, S_HFP, S_HS, S_HBP, S_VA, S_VFP, S_VS, 1'b0, 1'b1));
  endtask

  initial begin
    int hs_count;
    int last_fs;
    int enables;
    reset  = 1'b0;
    pix_en = 1'b0;

    // Reset with and without enable, then hold idle so the reset levels must persist.
    apply_stimulus(1'b0, 1'b1);
    apply_stimulus(1'b0, 1'b0);
    apply_stimulus(1'b1, 1'b0);

    // First enabled clock lands on pixel (0,0) with both strobes.
    apply_stimulus(1'b1, 1'b1);
    checks++;
    assert (vid_d.frame_start === 1'b1 && vid_d.line_start === 1'b1 && vid_d.de === 1'b1) else begin
      errors++; $error("[TB] FAIL first_pixel observed fs=%b ls=%b de=%b expected 1 1 1",
                       vid_d.frame_start, vid_d.line_start, vid_d.de);
    end
    hs_count = 0;
    last_fs  = 0;
    enables  = 1;

    // Continuous enable across two full 1080p lines and many small frames.
    for (int i = 0; i < 4500; i++) begin
      apply_stimulus(1'b1, 1'b1);
      enables++;
      if (enables <= D_HT && vid_d.hsync === 1'b1) hs_count++;
      if (vid_s.frame_start === 1'b1) begin
        checks++;
        assert (enables - 1 - last_fs === S_HT * S_VT) else begin
          errors++; $error("[TB] FAIL small_period observed %0d expected %0d", enables - 1 - last_fs, S_HT * S_VT);
        end
        last_fs = enables - 1;
      end
    end
    checks++;
    assert (hs_count === D_HS) else begin
      errors++; $error("[TB] FAIL hsync_width observed %0d expected %0d", hs_count, D_HS);
    end
    checks++;
    assert (vid_d.y === 11'd2) else begin
      errors++; $error("[TB] FAIL line_count observed %0d expected 2", vid_d.y);
    end

    // Random enable gaps: levels hold, strobes are single-clock.
    for (int i = 0; i < 3000; i++)
      apply_stimulus(1'b1, 1'($urandom_range(0, 2) != 0));

    // Random mid-frame resets mixed with random gaps.
    for (int i = 0; i < 3000; i++)
      apply_stimulus(1'($urandom_range(0, 299) != 0), 1'($urandom_range(0, 3) != 0));

    // Directed mid-frame reset with enable low.
    for (int i = 0; i < 37; i++) apply_stimulus(1'b1, 1'b1);
    apply_stimulus(1'b0, 1'b0);
    checks++;
    assert (vid_s.de === 1'b0 && vid_s.hsync === 1'b1 && vid_s.vsync === 1'b0) else begin
      errors++; $error("[TB] FAIL midframe_reset observed de=%b hs=%b vs=%b expected 0 1 0",
                       vid_s.de, vid_s.hsync, vid_s.vsync);
    end
    apply_stimulus(1'b1, 1'b1);
    for (int i = 0; i < 200; i++) apply_stimulus(1'b1, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Generates the raster timing for the display output: active-area pixel coordinates, hsync, vsync and data-enable.
- Also produces line-start and frame-start strobes, advancing once per pixel-clock enable.
- Sits downstream of the pixel-counter stage. It consumes the same x/y raster walk, extended with front porch, sync and back porch, and feeds the output encoder and the framebuffer fetch unit.
- Default timing is 1920x1080 CEA-861 (2200x1125 total).

Parameters:
- H_ACTIVE, 1920, active pixels per line
- H_FP, 88, horizontal front porch (pixels)
- H_SYNC, 44, hsync width (pixels)
- H_BP, 148, horizontal back porch (pixels)
- V_ACTIVE, 1080, active lines per frame
- V_FP, 4, vertical front porch (lines)
- V_SYNC, 5, vsync width (lines)
- V_BP, 36, vertical back porch (lines)
- HS_POL, 1, hsync asserted level
- VS_POL, 1, vsync asserted level

Ports:
- clk  in  1  system clock
- reset  in  1  reset reset, synchronous, active-low
- pix_en  in  1  pixel-clock enable; raster advances one pixel per clk where pix_en=1
- x  out  12  active pixel column, 0..H_ACTIVE-1; 0 when de=0
- y  out  11  active line, 0..V_ACTIVE-1; 0 when de=0
- de  out  1  data enable, 1 inside active area
- hsync  out  1  horizontal sync, level per HS_POL
- vsync  out  1  vertical sync, level per VS_POL
- line_start  out  1  single-clk strobe when h_cnt becomes 0
- frame_start  out  1  single-clk strobe when h_cnt and v_cnt both become 0

Behaviour:
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- Internal counters: h_cnt (12 b) and v_cnt (11 b).
- Line layout: active first, then FP, SYNC, BP.
- Reset (reset=0 at a clk edge): h_cnt=H_TOTAL-1, v_cnt=V_TOTAL-1 (pre-start point, inside both back porches).
  - Outputs: de=0, x=0, y=0, hsync=~HS_POL, vsync=~VS_POL, line_start=0, frame_start=0.
  - Reset takes priority over pix_en and is honoured mid-line or mid-frame.
- Advance (reset=1, pix_en=1):
  - h_cnt wraps H_TOTAL-1 -> 0, otherwise increments.
  - v_cnt changes only when h_cnt wraps: V_TOTAL-1 -> 0, otherwise +1.
- Hold (pix_en=0): counters and level outputs hold; line_start and frame_start clear to 0.
- All outputs are registers, decoded on the same edge from the next counter values. Outputs therefore describe the pixel the counters now point at (zero latency relative to the counters). The first enabled clk after reset yields h=0, v=0.
- Decode:
  - de = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
  - x = de ? h_cnt : 0; y = de ? v_cnt : 0.
  - hsync = HS_POL while H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC, else ~HS_POL.
  - vsync = VS_POL while V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC (whole lines, switching at h_cnt=0), else ~VS_POL.
  - line_start = 1 for one clk on the advance that produces h_cnt=0.
  - frame_start = 1 for one clk on the advance that produces h_cnt=0 and v_cnt=0; line_start is also 1 on that clk.
- Width rules: H_TOTAL must be <= 4096 and V_TOTAL <= 2048. All comparisons are unsigned. No other parameter checking is performed.

Test Plan:
- Reset, then one pix_en clk -> frame_start=1, line_start=1, de=1, x=0, y=0, hsync=0, vsync=0. Next enabled clk -> both strobes 0, x=1.
- 1920 enabled clks from line start -> x=1919 on the last. Next clk -> de=0, x=0. hsync=1 for h_cnt 2008..2051 (exactly 44 enabled clks).
- End of line 0 at h_cnt=2199 -> next advance gives x=0, y=1, de=1, line_start=1, frame_start=0.
- vsync=1 from v_cnt 1084 through 1088 (5 full lines, 11000 enables) and 0 elsewhere. de=0 throughout lines 1080..1124.
- 2,475,000 enabled clks after the first frame_start -> frame_start pulses again. Repeat with small params (8/2/2/2, 4/1/1/1): period is 14*7 = 98 enables.
- Random pix_en gaps: outputs hold during gaps and strobes last exactly one clk. reset=0 mid-frame -> pre-start state and reset output values on the next clk, regardless of pix_en.
